tlu_dut_handshake: RTL and testbench

DUT-side responder for the TLU trigger/busy/clock handshake driven by `tlu_master_core`. It detects a trigger from the TLU and raises busy. It then clocks the serial trigger number out of the TLU, presents the decoded number on a valid/ready output, and releases busy. It sits in the DUT readout firmware, or in the simulation bench opposite the master, and its number stream is checked against the master's FIFO.

---
 rtl/tlu_dut_handshake_pkg.sv | 28 ++
 rtl/tlu_dut_handshake_sync_2ff.sv | 26 ++
 rtl/tlu_dut_handshake.sv | 129 ++++++++++++
 tb/tb_tlu_dut_handshake.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlu_dut_handshake_pkg.sv
// Shared definitions for the DUT-side TLU handshake responder.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package tlu_dut_handshake_pkg;

    // Trigger-number width shifted out of the TLU per handshake.
    localparam int TRIG_BITS_DEF = 15;

    // Shortest TLU_CLOCK half period the responder will generate.
    localparam logic [7:0] HALF_PERIOD_MIN = 8'd4;

    // Handshake FSM encoding.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BUSY     = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_DONE     = 3'd4,
        ST_ABORT    = 3'd5,
        ST_REARM    = 3'd6
    } state_t;

    // Clamp the requested half period so the master always sees a slow enough clock.
    function automatic logic [7:0] eff_half_period(input logic [7:0] hp);
        return (hp < HALF_PERIOD_MIN) ? HALF_PERIOD_MIN : hp;
    endfunction

endpackage

// File: rtl/tlu_dut_handshake_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs into the clk domain.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; samples every cycle.
module tlu_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tlu_dut_handshake.sv
// DUT-side TLU responder: trigger detect, busy, serial number read-out, valid/ready output.
// Latency: TLU_TRIGGER rise to TLU_BUSY 3 cycles; first TLU_CLOCK rise to DATA_VALID TRIG_BITS*2*HP+1.
// Backpressure: single-entry output; while DATA_VALID waits for DATA_READY, TLU_BUSY stays high.
module tlu_dut_handshake
    import tlu_dut_handshake_pkg::*;
#(
    parameter int TRIG_BITS = TRIG_BITS_DEF
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 ENABLE,
    input  logic [7:0]           HALF_PERIOD,
    input  logic [15:0]          TIMEOUT,
    input  logic                 TLU_TRIGGER,
    output logic                 TLU_BUSY,
    output logic                 TLU_CLOCK,
    output logic                 DATA_VALID,
    input  logic                 DATA_READY,
    output logic [TRIG_BITS-1:0] DATA,
    output logic [31:0]          TRIG_CNT,
    output logic [7:0]           ERR_CNT
);

    localparam int BW = (TRIG_BITS > 1) ? $clog2(TRIG_BITS) : 1;

    state_t               state;
    state_t               next_state;
    logic                 trig_s;
    logic                 trig_s_d;
    logic                 trig_rise;
    logic [7:0]           hp_eff;
    logic [7:0]           pcnt;
    logic [15:0]          tcnt;
    logic [BW-1:0]        bitcnt;
    logic [TRIG_BITS-1:0] shreg;
    logic                 loaded;
    logic                 period_last;
    logic                 bit_last;
    logic                 tmo_hit;

    tlu_sync_2ff #(.WIDTH(1)) u_trig_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (TLU_TRIGGER),
        .q     (trig_s)
    );

    assign trig_rise   = trig_s & ~trig_s_d;
    assign hp_eff      = eff_half_period(HALF_PERIOD);
    assign period_last = (pcnt == hp_eff - 8'd1);
    assign bit_last    = (bitcnt == BW'(TRIG_BITS - 1));
    // tcnt holds completed BUSY cycles, so this cycle is the TIMEOUT-th one.
    assign tmo_hit     = (TIMEOUT != 16'd0) && ((tcnt + 16'd1) == TIMEOUT);

    // Next-state decode; a held trigger in BUSY wins over a timeout only when it has dropped.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (trig_rise && ENABLE) next_state = ST_BUSY;
            ST_BUSY:     if (!trig_s) next_state = ST_SHIFT_HI;
                         else if (tmo_hit) next_state = ST_ABORT;
            ST_SHIFT_HI: if (period_last) next_state = ST_SHIFT_LO;
            ST_SHIFT_LO: if (period_last) next_state = bit_last ? ST_DONE : ST_SHIFT_HI;
            ST_DONE:     if (loaded && !DATA_VALID) next_state = ST_REARM;
            ST_ABORT:    next_state = ST_REARM;
            ST_REARM:    if (!trig_s) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // State, registered handshake outputs and the period/timeout/bit counters with the shift register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            trig_s_d  <= 1'b0;
            TLU_BUSY  <= 1'b0;
            TLU_CLOCK <= 1'b0;
            pcnt      <= '0;
            tcnt      <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
        end else begin
            state     <= next_state;
            trig_s_d  <= trig_s;
            // Outputs follow next_state so they switch on the same edge as the state.
            TLU_BUSY  <= (next_state != ST_IDLE) && (next_state != ST_REARM);
            TLU_CLOCK <= (next_state == ST_SHIFT_HI);
            pcnt      <= ((next_state == state) &&
                          (state == ST_SHIFT_HI || state == ST_SHIFT_LO)) ? pcnt + 8'd1 : 8'd0;
            tcnt      <= (state == ST_BUSY) ? tcnt + 16'd1 : 16'd0;
            if (state == ST_BUSY) begin
                bitcnt <= '0;
            end else if (state == ST_SHIFT_LO && period_last) begin
                // Sample at the end of the low phase, furthest from the master's data change.
                shreg[bitcnt] <= trig_s;
                bitcnt        <= bitcnt + BW'(1);
            end
        end
    end

    // Single-entry output register plus handshake and error counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DATA       <= '0;
            DATA_VALID <= 1'b0;
            TRIG_CNT   <= '0;
            ERR_CNT    <= '0;
            loaded     <= 1'b0;
        end else begin
            if (state == ST_DONE && !loaded && !DATA_VALID) begin
                DATA       <= shreg;
                DATA_VALID <= 1'b1;
                TRIG_CNT   <= TRIG_CNT + 32'd1;
            end else if (DATA_VALID && DATA_READY) begin
                DATA_VALID <= 1'b0;
            end
            // loaded marks that this DONE visit already produced its word.
            if (state != ST_DONE) begin
                loaded <= 1'b0;
            end else if (!DATA_VALID) begin
                loaded <= 1'b1;
            end
            if (state == ST_ABORT && ERR_CNT != 8'hFF) begin
                ERR_CNT <= ERR_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tlu_dut_handshake.sv
// Directed bench: plays the TLU master and scoreboards the decoded trigger numbers.
// Latency: checks busy, bit period, handshake length and release timing per scenario.
// Backpressure: exercises DATA_READY low stall and release.
module tb_tlu_dut_handshake;
    import tlu_dut_handshake_pkg::*;

    localparam int TB = TRIG_BITS_DEF;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          ENABLE;
    logic [7:0]    HALF_PERIOD;
    logic [15:0]   TIMEOUT;
    logic          TLU_TRIGGER;
    logic          TLU_BUSY;
    logic          TLU_CLOCK;
    logic          DATA_VALID;
    logic          DATA_READY;
    logic [TB-1:0] DATA;
    logic [31:0]   TRIG_CNT;
    logic [7:0]    ERR_CNT;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            n_valid = 0;
    int            lat_busy;
    int            t_rise0;
    int            n_rises;
    int            per_bad;
    logic [TB-1:0] exp_q[$];

    tlu_dut_handshake dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .ENABLE      (ENABLE),
        .HALF_PERIOD (HALF_PERIOD),
        .TIMEOUT     (TIMEOUT),
        .TLU_TRIGGER (TLU_TRIGGER),
        .TLU_BUSY    (TLU_BUSY),
        .TLU_CLOCK   (TLU_CLOCK),
        .DATA_VALID  (DATA_VALID),
        .DATA_READY  (DATA_READY),
        .DATA        (DATA),
        .TRIG_CNT    (TRIG_CNT),
        .ERR_CNT     (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted word must match the oldest number sent.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && DATA_VALID === 1'b1 && DATA_READY === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) check("sb_unexpected_valid", 32'(DATA_VALID), 32'd0);
            else check("sb_data", 32'(DATA), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_busy(input string tag, input logic v, input int budget);
        int c = 0;
        while (TLU_BUSY !== v && c < budget) begin
            @(posedge CLK);
            #1;
            c++;
        end
        check(tag, 32'(TLU_BUSY), 32'(v));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int c = 0;
        while (DATA_VALID !== 1'b1 && c < budget) begin
            @(posedge CLK);
            #1;
            c++;
        end
        check(tag, 32'(DATA_VALID), 32'd1);
    endtask

    task automatic wait_clk_rise(input int budget, output logic hit);
        logic prev;
        int   c = 0;
        hit  = 1'b0;
        prev = TLU_CLOCK;
        while (!hit && c < budget) begin
            @(posedge CLK);
            #1;
            c++;
            hit  = (prev === 1'b0 && TLU_CLOCK === 1'b1);
            prev = TLU_CLOCK;
        end
    endtask

    // Master side: trigger, wait busy, then put bit k on the line after clock rise k.
    task automatic send_num(input logic [TB-1:0] num, input int period);
        logic hit;
        int   t0;
        int   t_prev = 0;
        t0 = cyc;
        TLU_TRIGGER = 1'b1;
        wait_busy("busy_rise", 1'b1, 20);
        lat_busy = cyc - t0;
        TLU_TRIGGER = 1'b0;
        n_rises = 0;
        per_bad = 0;
        for (int k = 0; k < TB; k++) begin
            wait_clk_rise(4 * period + 16, hit);
            if (!hit) break;
            if (k == 0) t_rise0 = cyc;
            else if (cyc - t_prev != period) per_bad++;
            t_prev = cyc;
            n_rises++;
            TLU_TRIGGER = num[k];
        end
    endtask

    task automatic finish_handshake();
        wait_busy("busy_release", 1'b0, 50);
        TLU_TRIGGER = 1'b0;
        tick(6);
    endtask

    initial begin
        logic          hit;
        logic [TB-1:0] held;
        logic [31:0]   base;
        int            bad;
        int            v0;

        RST_N       = 1'b0;
        ENABLE      = 1'b1;
        HALF_PERIOD = 8'd4;
        TIMEOUT     = 16'd0;
        TLU_TRIGGER = 1'b0;
        DATA_READY  = 1'b1;
        tick(3);
        check("rst_busy",     32'(TLU_BUSY),   32'd0);
        check("rst_clock",    32'(TLU_CLOCK),  32'd0);
        check("rst_valid",    32'(DATA_VALID), 32'd0);
        check("rst_data",     32'(DATA),       32'd0);
        check("rst_trig_cnt", TRIG_CNT,        32'd0);
        check("rst_err_cnt",  32'(ERR_CNT),    32'd0);
        RST_N = 1'b1;
        tick(3);

        // Single handshake, number 0x2A5B, HALF_PERIOD 4.
        exp_q.push_back(15'h2A5B);
        send_num(15'h2A5B, 8);
        check("t1_busy_latency", 32'(lat_busy), 32'd3);
        check("t1_clock_pulses", 32'(n_rises),  32'd15);
        check("t1_bit_period",   32'(per_bad),  32'd0);
        wait_valid("t1_valid", 100);
        check("t1_handshake_len", 32'(cyc - t_rise0), 32'(15 * 2 * 4 + 1));
        tick(1);
        check("t1_valid_one_cycle", 32'(DATA_VALID), 32'd0);
        check("t1_trig_cnt", TRIG_CNT, 32'd1);
        finish_handshake();

        // 100 back-to-back handshakes numbered 0..99.
        base = TRIG_CNT;
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back(TB'(i));
            send_num(TB'(i), 8);
            wait_valid("t2_valid", 100);
            finish_handshake();
        end
        check("t2_trig_cnt",   TRIG_CNT - base, 32'd100);
        check("t2_err_cnt",    32'(ERR_CNT), 32'd0);
        check("t2_sb_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: READY low for 500 cycles after DONE.
        DATA_READY = 1'b0;
        exp_q.push_back(15'h1234);
        send_num(15'h1234, 8);
        wait_valid("t3_valid", 100);
        held = DATA;
        bad  = 0;
        repeat (500) begin
            tick(1);
            if (TLU_BUSY !== 1'b1 || TLU_CLOCK !== 1'b0 || DATA_VALID !== 1'b1 || DATA !== held) bad++;
        end
        check("t3_stall_hold", 32'(bad), 32'd0);
        check("t3_held_data",  32'(DATA), 32'h1234);
        DATA_READY = 1'b1;
        tick(1);
        check("t3_valid_cleared", 32'(DATA_VALID), 32'd0);
        check("t3_busy_still_hi", 32'(TLU_BUSY), 32'd1);
        tick(1);
        check("t3_busy_drop", 32'(TLU_BUSY), 32'd0);
        TLU_TRIGGER = 1'b0;
        tick(6);

        // Timeout: trigger held high, TIMEOUT 50.
        TIMEOUT = 16'd50;
        v0 = n_valid;
        TLU_TRIGGER = 1'b1;
        wait_busy("t4_busy", 1'b1, 20);
        tick(47);
        check("t4_busy_before_abort", 32'(TLU_BUSY), 32'd1);
        check("t4_err_before_abort",  32'(ERR_CNT),  32'd0);
        tick(4);
        check("t4_busy_after_abort", 32'(TLU_BUSY), 32'd0);
        check("t4_err_after_abort",  32'(ERR_CNT),  32'd1);
        bad = 0;
        repeat (20) begin
            tick(1);
            if (TLU_BUSY !== 1'b0) bad++;
        end
        check("t4_no_retrigger", 32'(bad), 32'd0);
        check("t4_no_valid", 32'(n_valid - v0), 32'd0);
        TLU_TRIGGER = 1'b0;
        TIMEOUT = 16'd0;
        tick(6);
        exp_q.push_back(15'h0055);
        send_num(15'h0055, 8);
        wait_valid("t4_recover_valid", 100);
        finish_handshake();
        check("t4_err_kept", 32'(ERR_CNT), 32'd1);

        // Asynchronous reset during bit 7, then number 0x0001.
        TLU_TRIGGER = 1'b1;
        wait_busy("t5_busy", 1'b1, 20);
        TLU_TRIGGER = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_clk_rise(60, hit);
            TLU_TRIGGER = k[0];
        end
        tick(2);
        check("t5_clock_high_pre", 32'(TLU_CLOCK), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        check("t5_clock_async_low", 32'(TLU_CLOCK), 32'd0);
        check("t5_busy_async_low",  32'(TLU_BUSY),  32'd0);
        tick(2);
        RST_N = 1'b1;
        TLU_TRIGGER = 1'b0;
        tick(4);
        check("t5_trig_cnt_reset", TRIG_CNT, 32'd0);
        exp_q.push_back(15'h0001);
        send_num(15'h0001, 8);
        wait_valid("t5_valid", 100);
        check("t5_trig_cnt", TRIG_CNT, 32'd1);
        finish_handshake();

        // ENABLE low ignores a trigger; HALF_PERIOD 1 behaves as 4.
        ENABLE = 1'b0;
        base = TRIG_CNT;
        TLU_TRIGGER = 1'b1;
        bad = 0;
        repeat (5) begin
            tick(1);
            if (TLU_BUSY !== 1'b0) bad++;
        end
        TLU_TRIGGER = 1'b0;
        repeat (20) begin
            tick(1);
            if (TLU_BUSY !== 1'b0) bad++;
        end
        check("t6_disabled_busy", 32'(bad), 32'd0);
        check("t6_disabled_cnt",  TRIG_CNT, base);
        ENABLE = 1'b1;
        HALF_PERIOD = 8'd1;
        exp_q.push_back(15'h0AAA);
        send_num(15'h0AAA, 8);
        check("t6_hp_clamp_period", 32'(per_bad), 32'd0);
        check("t6_hp_clamp_pulses", 32'(n_rises), 32'd15);
        wait_valid("t6_valid", 100);
        check("t6_handshake_len", 32'(cyc - t_rise0), 32'(15 * 2 * 4 + 1));
        finish_handshake();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
